// File: rtl/rd_sched_pkg.sv
// Shared types and default timing constants for the telemetry read-port scheduler
// and the UART transmit controllers that consume its frames.
package rd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOT = 2'd1,
    ADV  = 2'd2,
    FIN  = 2'd3
  } sched_state_e;

  localparam int FRAME_LEN = 18;
  localparam int SLOT_LEN  = 64;
  localparam int RD_START  = 40;
  localparam int RD_WIDTH  = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: returns the first pending index after the
// pointer, wrapping modulo N_CH.
module rr_arbiter #(
  parameter int N_CH = 5
) (
  input  logic [N_CH-1:0] pending_i,
  input  logic [2:0]      pointer_i,
  input  logic            en_i,
  output logic            valid_o,
  output logic [2:0]      grant_o
);

  localparam int IW = $clog2(N_CH);

  // Scan from farthest to nearest so the nearest pending index overwrites.
  always_comb begin
    int cand;
    valid_o = 1'b0;
    grant_o = '0;
    cand    = 0;
    for (int k = N_CH; k >= 1; k--) begin
      cand = (int'(pointer_i) + k) % N_CH;
      if (en_i && pending_i[IW'(cand)]) begin
        valid_o = 1'b1;
        grant_o = 3'(cand);
      end
    end
  end

endmodule

// File: rtl/rd_port_scheduler.sv
// Shares one telemetry memory read port among N_CH UART channels: round-robin
// frame grants, per-word address sequencing and a timed read strobe.
module rd_port_scheduler
  import rd_sched_pkg::*;
#(
  parameter int N_CH      = 5,
  parameter int FRAME_LEN = rd_sched_pkg::FRAME_LEN,
  parameter int ADDR_W    = 5,
  parameter int SLOT_LEN  = rd_sched_pkg::SLOT_LEN,
  parameter int RD_START  = rd_sched_pkg::RD_START,
  parameter int RD_WIDTH  = rd_sched_pkg::RD_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   req,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_adr,
  output logic [N_CH-1:0]   rd_sel,
  output logic              busy,
  output logic [2:0]        grant_id,
  output logic [N_CH-1:0]   done
);

  localparam int SC_W = $clog2(SLOT_LEN);
  localparam logic [SC_W-1:0]   SLOT_LAST = SC_W'(SLOT_LEN - 1);
  localparam logic [SC_W-1:0]   RD_FIRST  = SC_W'(RD_START);
  localparam logic [SC_W-1:0]   RD_STOP   = SC_W'(RD_START + RD_WIDTH);
  localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(FRAME_LEN - 1);

  sched_state_e      state_q, state_d;
  logic [N_CH-1:0]   reqSync1_q, reqSync2_q, reqPrev_q;
  logic [N_CH-1:0]   pending_q, pending_d, done_q, done_d;
  logic [SC_W-1:0]   slotCnt_q, slotCnt_d;
  logic [ADDR_W-1:0] wordCnt_q, wordCnt_d;
  logic [2:0]        grant_q, grant_d, rrPtr_q, rrPtr_d, arbIdx;
  logic              busy_q, busy_d, rdEn_q, rdEn_d, arbValid;
  logic [N_CH-1:0]   reqRise, grantOh;

  assign reqRise = reqSync2_q & ~reqPrev_q;
  assign grantOh = N_CH'(1) << grant_q;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .pending_i (pending_q),
    .pointer_i (rrPtr_q),
    .en_i      (state_q == IDLE),
    .valid_o   (arbValid),
    .grant_o   (arbIdx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      reqSync1_q <= '0;
      reqSync2_q <= '0;
      reqPrev_q  <= '0;
      pending_q  <= '0;
      done_q     <= '0;
      slotCnt_q  <= '0;
      wordCnt_q  <= '0;
      grant_q    <= '0;
      rrPtr_q    <= 3'(N_CH - 1);
      busy_q     <= 1'b0;
      rdEn_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      reqSync1_q <= req;
      reqSync2_q <= reqSync1_q;
      reqPrev_q  <= reqSync2_q;
      pending_q  <= pending_d;
      done_q     <= done_d;
      slotCnt_q  <= slotCnt_d;
      wordCnt_q  <= wordCnt_d;
      grant_q    <= grant_d;
      rrPtr_q    <= rrPtr_d;
      busy_q     <= busy_d;
      rdEn_q     <= rdEn_d;
    end
  end

  // A request edge landing in the same clock as that channel's done re-arms it.
  always_comb begin
    state_d   = state_q;
    slotCnt_d = slotCnt_q;
    wordCnt_d = wordCnt_q;
    grant_d   = grant_q;
    rrPtr_d   = rrPtr_q;
    busy_d    = busy_q;
    done_d    = '0;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        if (arbValid) begin
          grant_d   = arbIdx;
          wordCnt_d = '0;
          slotCnt_d = '0;
          busy_d    = 1'b1;
          state_d   = SLOT;
        end
      end
      SLOT: begin
        if (slotCnt_q == SLOT_LAST) state_d = ADV;
        else                        slotCnt_d = slotCnt_q + 1'b1;
      end
      ADV: begin
        if (wordCnt_q == WORD_LAST) begin
          state_d = FIN;
        end else begin
          wordCnt_d = wordCnt_q + 1'b1;
          slotCnt_d = '0;
          state_d   = SLOT;
        end
      end
      FIN: begin
        done_d    = grantOh;
        pending_d = pending_q & ~grantOh;
        rrPtr_d   = grant_q;
        wordCnt_d = '0;
        slotCnt_d = '0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pending_d = pending_d | reqRise;

    rdEn_d = rdEn_q;
    if (state_d != SLOT || slotCnt_d == RD_STOP) rdEn_d = 1'b0;
    if (state_d == SLOT && slotCnt_d == RD_FIRST) rdEn_d = 1'b1;
  end

  assign rd_en    = rdEn_q;
  assign rd_adr   = wordCnt_q;
  assign rd_sel   = rdEn_q ? grantOh : '0;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rd_port_scheduler.sv
// Self-checking bench for rd_port_scheduler: directed scenarios plus random
// request strobes against a frame-window reference model.
module tb_rd_port_scheduler;

  localparam int N         = 5;
  localparam int FL        = 18;
  localparam int SL        = 64;
  localparam int RS        = 40;
  localparam int RW        = 4;
  localparam int SLOT_CLK  = SL + 1;
  localparam int FRAME_CLK = FL * SLOT_CLK + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] reqDrv = '0;
  logic         rdEn;
  logic [4:0]   rdAdr;
  logic [N-1:0] rdSel;
  logic         busy;
  logic [2:0]   grantId;
  logic [N-1:0] done;

  int nComp = 0;
  int nFail = 0;
  int cyc   = 0;

  // Reference model: pending set, and the active frame as a time window.
  logic [N-1:0] mPend, mDone, r1, r2, r3;
  bit           mActive;
  int           mG, mCh, mPtr, mGrants;

  int   dutCnt, dutSeq, dutDones, dutGrantCyc, dutDoneCyc;
  logic prevBusy;

  rd_port_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .req      (reqDrv),
    .rd_en    (rdEn),
    .rd_adr   (rdAdr),
    .rd_sel   (rdSel),
    .busy     (busy),
    .grant_id (grantId),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic cmpVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nComp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelReset();
    mPend = '0; mDone = '0; r1 = '0; r2 = '0; r3 = '0;
    mActive = 1'b0; mCh = 0; mPtr = N - 1;
  endtask

  task automatic modelStep(input logic [N-1:0] rNow);
    logic [N-1:0] setMask;
    logic [2:0]   c3;
    bit           found;
    setMask = r2 & ~r3;
    r3 = r2; r2 = r1; r1 = rNow;
    mDone = '0;
    if (mActive) begin
      if (cyc - mG == FRAME_CLK) begin
        c3 = 3'(mCh);
        mDone[c3] = 1'b1;
        mPend[c3] = 1'b0;
        mPtr = mCh;
        mActive = 1'b0;
      end
    end else if (mPend != '0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c3 = 3'((mPtr + k) % N);
        if (!found && mPend[c3]) begin
          found = 1'b1;
          mCh = (mPtr + k) % N;
        end
      end
      mActive = 1'b1;
      mG = cyc;
      mGrants++;
    end
    mPend = mPend | setMask;
  endtask

  task automatic checkOutput();
    logic         eEn;
    logic [N-1:0] eSel;
    logic [4:0]   eAdr;
    bit           adrKnown;
    int           o;
    eEn = 1'b0; eSel = '0; eAdr = '0; adrKnown = 1'b1;
    if (mActive) begin
      o = cyc - mG;
      if (o < FRAME_CLK - 1) begin
        eAdr = 5'(o / SLOT_CLK);
        if ((o % SLOT_CLK) >= RS && (o % SLOT_CLK) < RS + RW) begin
          eEn  = 1'b1;
          eSel = N'(1) << mCh;
        end
      end else begin
        adrKnown = 1'b0;
      end
    end
    cmpVal("busy", 32'(busy), 32'(mActive));
    cmpVal("grant_id", 32'(grantId), 32'(mCh));
    cmpVal("done", 32'(done), 32'(mDone));
    cmpVal("rd_en", 32'(rdEn), 32'(eEn));
    cmpVal("rd_sel", 32'(rdSel), 32'(eSel));
    if (adrKnown) cmpVal("rd_adr", 32'(rdAdr), 32'(eAdr));
    else          cmpVal("rd_adr_range", 32'(rdAdr <= 5'(FL - 1)), 32'd1);
    if (busy === 1'b1 && prevBusy !== 1'b1) begin
      dutCnt++;
      dutSeq = dutSeq * 8 + int'(grantId);
      dutGrantCyc = cyc;
    end
    prevBusy = busy;
    for (int i = 0; i < N; i++) begin
      if (done[i] === 1'b1) begin
        dutDones++;
        dutDoneCyc = cyc;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] rNow;
    @(posedge clk);
    rNow = reqDrv;
    cyc++;
    if (rst) modelStep(rNow);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [N-1:0] mask, input int width);
    reqDrv = reqDrv | mask;
    repeat (width) tick();
    reqDrv = reqDrv & ~mask;
  endtask

  task automatic runUntilIdle(input int maxc);
    int k;
    k = 0;
    while (!(!mActive && mPend == '0 && r1 == '0 && r2 == '0 && r3 == '0 && reqDrv == '0)
           && k < maxc) begin
      tick();
      k++;
    end
    if (k >= maxc) begin
      nComp++; nFail++;
      $display("[TB] FAIL idle_timeout observed=busy expected=idle within %0d cycles", maxc);
    end
  endtask

  task automatic waitOffset(input int target, input int maxc);
    int k;
    k = 0;
    while (!(mActive && cyc - mG == target) && k < maxc) begin
      tick();
      k++;
    end
    if (k >= maxc) begin
      nComp++; nFail++;
      $display("[TB] FAIL offset_timeout observed=none expected=offset %0d", target);
    end
  endtask

  task automatic startSection();
    dutCnt = 0; dutSeq = 0; dutDones = 0;
  endtask

  task automatic pulseReset();
    rst = 1'b0;
    modelReset();
    repeat (2) tick();
    rst = 1'b1;
  endtask

  initial begin
    int raiseCyc, g0;
    logic [N-1:0] rmask;
    modelReset();
    mGrants = 0; prevBusy = 1'b0; dutGrantCyc = 0; dutDoneCyc = 0;
    startSection();

    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();

    $display("[TB] single request on channel 2");
    startSection();
    raiseCyc = cyc;
    applyStimulus(5'b00100, 3);
    runUntilIdle(2 * FRAME_CLK);
    cmpVal("single_frames", 32'(dutCnt), 32'd1);
    cmpVal("single_order", 32'(dutSeq), 32'd2);
    cmpVal("single_dones", 32'(dutDones), 32'd1);
    cmpVal("grant_latency", 32'(dutGrantCyc - raiseCyc), 32'd4);
    cmpVal("done_latency", 32'(dutDoneCyc - dutGrantCyc), 32'(FRAME_CLK));

    $display("[TB] simultaneous requests 0,3,4 from reset");
    pulseReset();
    startSection();
    applyStimulus(5'b11001, 2);
    runUntilIdle(4 * FRAME_CLK);
    cmpVal("multi_frames", 32'(dutCnt), 32'd3);
    cmpVal("multi_order", 32'(dutSeq), 32'(0 * 64 + 3 * 8 + 4));
    cmpVal("multi_dones", 32'(dutDones), 32'd3);

    $display("[TB] fairness between channels 0 and 1");
    startSection();
    applyStimulus(5'b00011, 2);
    for (int f = 0; f < 3; f++) begin
      waitOffset(500, 2 * FRAME_CLK);
      applyStimulus(5'b00011, 2);
    end
    runUntilIdle(3 * FRAME_CLK);
    cmpVal("fair_frames", 32'(dutCnt), 32'd4);
    cmpVal("fair_order", 32'(dutSeq), 32'(0 * 512 + 1 * 64 + 0 * 8 + 1));

    $display("[TB] double strobe with done-cycle collision");
    startSection();
    applyStimulus(5'b00100, 2);
    waitOffset(300, 2 * FRAME_CLK);
    applyStimulus(5'b00100, 2);
    waitOffset(FRAME_CLK - 3, 2 * FRAME_CLK);
    applyStimulus(5'b00100, 2);
    runUntilIdle(3 * FRAME_CLK);
    cmpVal("dbl_frames", 32'(dutCnt), 32'd2);
    cmpVal("dbl_order", 32'(dutSeq), 32'(2 * 8 + 2));
    cmpVal("dbl_dones", 32'(dutDones), 32'd2);

    $display("[TB] reset mid-frame at word 9 slot 42");
    startSection();
    applyStimulus(5'b01000, 2);
    waitOffset(9 * SLOT_CLK + 42, 2 * FRAME_CLK);
    cmpVal("rd_en_before_reset", 32'(rdEn), 32'd1);
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput();
    repeat (2) tick();
    rst = 1'b1;
    repeat (4) tick();
    cmpVal("reset_no_done", 32'(dutDones), 32'd0);
    startSection();
    applyStimulus(5'b01000, 2);
    runUntilIdle(2 * FRAME_CLK);
    cmpVal("after_reset_frames", 32'(dutCnt), 32'd1);
    cmpVal("after_reset_dones", 32'(dutDones), 32'd1);

    $display("[TB] one-clock glitch on channel 4");
    startSection();
    g0 = mGrants;
    applyStimulus(5'b10000, 1);
    runUntilIdle(2 * FRAME_CLK);
    cmpVal("glitch_frames", 32'(dutCnt), 32'(mGrants - g0));
    cmpVal("glitch_dones", 32'(dutDones), 32'(mGrants - g0));

    $display("[TB] random request strobes");
    startSection();
    g0 = mGrants;
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 600)) tick();
      rmask = N'($urandom_range(1, (1 << N) - 1));
      applyStimulus(rmask, int'($urandom_range(1, 3)));
    end
    runUntilIdle(8 * FRAME_CLK);
    cmpVal("rand_frames", 32'(dutCnt), 32'(mGrants - g0));
    cmpVal("rand_dones", 32'(dutDones), 32'(mGrants - g0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
    $finish;
  end

endmodule

// File: doc/rd_port_scheduler.md
Name: rd_port_scheduler

Overview:
- Shares one read port of the telemetry word memory among N_CH UART output channels.
- Each channel raises a frame request strobe. The scheduler grants channels round-robin, one frame at a time.
- For each granted frame it sequences FRAME_LEN word reads: it generates the word address and a timed RD pulse, and steers the read into the granted channel's latch.
- Sits between the per-channel UART transmit controllers and the shared ROM/RAM read port.

Parameters:
- N_CH, 5, number of requesting channels (2..8)
- FRAME_LEN, 18, words read per granted frame
- ADDR_W, 5, word address width; must satisfy FRAME_LEN <= 2**ADDR_W
- SLOT_LEN, 64, clocks per word slot
- RD_START, 40, slot cycle at which rd_en rises
- RD_WIDTH, 4, rd_en high time in clocks; must satisfy RD_START+RD_WIDTH <= SLOT_LEN

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- req  in  N_CH  frame request strobes, asynchronous, level, one per channel
- rd_en  out  1  memory read pulse
- rd_adr  out  ADDR_W  word address within frame
- rd_sel  out  N_CH  one-hot latch-load select, valid while rd_en=1, zero otherwise
- busy  out  1  high while a frame is in service
- grant_id  out  3  index of channel in service; holds last value when idle
- done  out  N_CH  one-clock pulse on the channel whose frame completed

Behaviour:
- Reset is rst, asynchronous, active-low; clock is clk.
- Reset values: rd_en=0, rd_adr=0, rd_sel=0, busy=0, grant_id=0, done=0, pending=0. Round-robin pointer=N_CH-1, so channel 0 has first priority.
- Request capture:
  - req passes a 2-flop synchronizer. A registered rising-edge detect on the synced value sets pending[i].
  - pending[i] sets 3 clocks after the raw rise. A req pulse shorter than 2 clk may be lost; this is legal.
- Edge and pending rules:
  - An edge while pending[i]=1 is absorbed; there is at most one outstanding frame per channel.
  - pending[i] clears on that channel's done. If an edge and done for the same channel occur in the same clock, set wins.
- States: IDLE, SLOT, ADV, FIN.
- IDLE:
  - busy=0.
  - If any pending bit is set, select the first pending index after the pointer (modulo N_CH), load grant_id, clear word_cnt and slot_cnt, and set busy=1.
  - Go to SLOT. The grant is registered one clock after pending is visible.
- SLOT:
  - slot_cnt increments 0..SLOT_LEN-1. rd_adr = word_cnt.
  - rd_en=1 for slot_cnt in [RD_START, RD_START+RD_WIDTH-1]. rd_sel = onehot(grant_id) on those same cycles.
  - When slot_cnt = SLOT_LEN-1: go to ADV.
- ADV (1 clk):
  - If word_cnt = FRAME_LEN-1, go to FIN.
  - Otherwise word_cnt+1, slot_cnt=0, back to SLOT.
- FIN (1 clk):
  - done[grant_id]=1, pending[grant_id] cleared, pointer=grant_id, word_cnt=0, rd_adr=0, busy=0. Go to IDLE.
- Frame duration from grant to done: FRAME_LEN*(SLOT_LEN+1)+1 clocks (1171 at defaults).
- Back-to-back frames: the next grant occurs 1 clk after FIN (in IDLE). busy drops for exactly 1 clk.
- Non-preemption: requests arriving mid-frame never preempt. They are arbitrated at the next IDLE.
- rd_adr never exceeds FRAME_LEN-1 and never wraps mid-frame. It is driven to 0 (not Z) while idle.
- Reset asserted mid-frame:
  - All outputs return to reset values immediately. The frame is abandoned with no done pulse.
  - Pending requests are lost; requesters must re-strobe.
- Counter widths: slot_cnt is clog2(SLOT_LEN); word_cnt is ADDR_W. Counters are compared for equality only.

Decomposition:
- Shared package rd_sched_pkg holds:
  - state enum values IDLE=0, SLOT=1, ADV=2, FIN=3;
  - the default constants FRAME_LEN, SLOT_LEN, RD_START, RD_WIDTH, shared with the UART transmit controllers.
- Sub-module rr_arbiter (N_CH):
  - inputs pending, pointer, and an arbitration enable;
  - outputs a valid flag and the grant index;
  - purely combinational round-robin select.
- The request synchronizer stays inline.

Test Plan:
- Single request: req[2] rises at t0 → busy rises at t0+4. 18 rd_en pulses each 4 clk wide, rd_adr 0..17, rd_sel=00100 during each pulse. done[2] pulses once, 1171 clk after grant.
- Simultaneous req[0], req[3], req[4] from reset → service order 0, 3, 4. busy low exactly 1 clk between frames. Each channel receives exactly one done.
- Fairness: hold req[1] high/low repeatedly with req[0] re-strobed every frame → grants alternate 0, 1, 0, 1 with no starvation.
- Double strobe: req[2] toggled twice during its own frame → exactly one extra frame follows; pending is set on done-cycle collision.
- Reset at word 9, slot 42 of a frame (rd_en=1) → all outputs 0 on the next edge, no done. A fresh req afterwards is served starting from rd_adr=0.
- Glitch: a 1-clk req[4] pulse aligned mid-cycle → either no grant or exactly one full frame; never a partial frame or X on rd_adr.
